// File: rtl/control_motor_pkg.sv
// Shared types and constants for the stepper move sequencer.
package control_motor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MOVIENDO = 2'd1,
    ASENTAR  = 2'd2
  } estado_t;

  localparam int PERIODO_MIN_DEF = 2;

  // Full-step pattern, entry 0 in the low nibble: 1100, 0110, 0011, 1001
  localparam logic [3:0][3:0] TABLA_FASES = {4'b1001, 4'b0011, 4'b0110, 4'b1100};

  function automatic logic [3:0] fase(input logic [1:0] idx);
    return TABLA_FASES[idx];
  endfunction

endpackage

// File: rtl/control_motor_temporizador_paso.sv
// Step/settle interval timer: down-counter that pulses every P enabled cycles after load.
module temporizador_paso #(
  parameter int W = 20
) (
  input  logic         clk_1,
  input  logic         rst_n,
  input  logic         carga,
  input  logic [W-1:0] valor,
  input  logic         habilita,
  output logic         expira
);

  localparam logic [W-1:0] UNO = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cuenta;
  logic [W-1:0] recarga;

  // Expiry is decoded from the count so the owner can act on the same edge it reloads.
  assign expira = habilita && !carga && (cuenta <= UNO);

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      cuenta  <= '0;
      recarga <= '0;
    end else if (carga) begin
      cuenta  <= valor;
      recarga <= valor;
    end else if (habilita) begin
      if (cuenta <= UNO) cuenta <= recarga;
      else               cuenta <= cuenta - UNO;
    end
  end

endmodule

// File: rtl/control_motor.sv
// Counted, direction-controlled stepper move sequencer with settle and abort.
module control_motor
  import control_motor_pkg::*;
#(
  parameter int W_PASOS     = 16,
  parameter int W_PERIODO   = 20,
  parameter int PERIODO_MIN = PERIODO_MIN_DEF
) (
  input  logic                 clk_1,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [W_PASOS-1:0]   cmd_pasos,
  input  logic                 cmd_sentido,
  input  logic [W_PERIODO-1:0] cmd_periodo,
  input  logic                 parar,
  output logic [3:0]           M,
  output logic                 motor_activo,
  output logic [W_PASOS-1:0]   pasos_rest,
  output logic                 hecho,
  output logic                 abortado
);

  localparam logic [W_PASOS-1:0]   UNO_P = {{(W_PASOS-1){1'b0}}, 1'b1};
  localparam logic [W_PERIODO-1:0] P_MIN = W_PERIODO'(PERIODO_MIN);

  estado_t estado, estado_sig;

  logic                 aceptar, paso, fin, aborta, cero;
  logic                 cero_pend;
  logic                 sentido_r;
  logic [1:0]           indice, indice_sig;
  logic [W_PERIODO-1:0] p_clamp;
  logic                 expira;

  assign cmd_ready  = (estado == IDLE) && !parar;
  assign p_clamp    = (cmd_periodo < P_MIN) ? P_MIN : cmd_periodo;
  assign indice_sig = sentido_r ? indice + 2'd1 : indice - 2'd1;

  temporizador_paso #(.W(W_PERIODO)) u_temp (
    .clk_1    (clk_1),
    .rst_n    (rst_n),
    .carga    (aceptar),
    .valor    (p_clamp),
    .habilita (estado != IDLE),
    .expira   (expira)
  );

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    aceptar    = 1'b0;
    paso       = 1'b0;
    fin        = 1'b0;
    aborta     = 1'b0;
    cero       = 1'b0;
    case (estado)
      IDLE: begin
        if (cmd_valid && !parar) begin
          aceptar = 1'b1;
          if (cmd_pasos != '0) estado_sig = MOVIENDO;
          else                 cero       = 1'b1;
        end
      end
      MOVIENDO: begin
        // Abort takes priority over a coincident step.
        if (parar) begin
          aborta     = 1'b1;
          estado_sig = IDLE;
        end else if (expira) begin
          paso = 1'b1;
          if (pasos_rest <= UNO_P) estado_sig = ASENTAR;
        end
      end
      ASENTAR: begin
        if (parar) begin
          aborta     = 1'b1;
          estado_sig = IDLE;
        end else if (expira) begin
          fin        = 1'b1;
          estado_sig = IDLE;
        end
      end
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      sentido_r    <= 1'b0;
      indice       <= 2'd0;
      pasos_rest   <= '0;
      cero_pend    <= 1'b0;
      hecho        <= 1'b0;
      abortado     <= 1'b0;
      M            <= 4'b0000;
      motor_activo <= 1'b0;
    end else begin
      if (aceptar) begin
        sentido_r  <= cmd_sentido;
        pasos_rest <= cmd_pasos;
      end else if (paso) begin
        indice <= indice_sig;
        if (pasos_rest != '0) pasos_rest <= pasos_rest - UNO_P;
      end
      // Zero-step commands complete one cycle after acceptance.
      cero_pend    <= cero;
      hecho        <= cero_pend | fin | aborta;
      abortado     <= aborta;
      motor_activo <= (estado_sig != IDLE);
      M            <= (estado_sig != IDLE) ? fase(paso ? indice_sig : indice) : 4'b0000;
    end
  end

endmodule

// File: tb/tb_control_motor.sv
// Directed bench for control_motor: vector table of moves plus abort/contention/reset sequences.
module tb_control_motor;

  logic        clk_1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_pasos = '0;
  logic        cmd_sentido = 1'b0;
  logic [19:0] cmd_periodo = '0;
  logic        parar = 1'b0;
  logic [3:0]  M;
  logic        motor_activo;
  logic [15:0] pasos_rest;
  logic        hecho;
  logic        abortado;

  int checks = 0;
  int errors = 0;

  always #5 clk_1 = ~clk_1;

  control_motor dut (
    .clk_1        (clk_1),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_pasos    (cmd_pasos),
    .cmd_sentido  (cmd_sentido),
    .cmd_periodo  (cmd_periodo),
    .parar        (parar),
    .M            (M),
    .motor_activo (motor_activo),
    .pasos_rest   (pasos_rest),
    .hecho        (hecho),
    .abortado     (abortado)
  );

  typedef struct {
    bit              rst_first;
    logic [15:0]     pasos;
    logic            sentido;
    logic [19:0]     periodo;
    int              p_eff;
    logic [4:0][3:0] m;
  } move_t;

  move_t vec [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk_1);
    @(negedge clk_1);
    rst_n = 1'b1;
  endtask

  // Returns #1 after the accept edge k; the next negedge is sample t=0.
  task automatic accept(input logic [15:0] p, input logic s, input logic [19:0] per);
    @(negedge clk_1);
    cmd_pasos   = p;
    cmd_sentido = s;
    cmd_periodo = per;
    cmd_valid   = 1'b1;
    #1 chk("ready_before_accept", cmd_ready, 1);
    @(posedge clk_1);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    vec[0] = '{1'b1, 16'd3, 1'b1, 20'd4, 4, {4'b0000, 4'b1001, 4'b0011, 4'b0110, 4'b1100}};
    vec[1] = '{1'b1, 16'd2, 1'b0, 20'd0, 2, {4'b0000, 4'b0000, 4'b0011, 4'b1001, 4'b1100}};
    vec[2] = '{1'b0, 16'd1, 1'b1, 20'd3, 3, {4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0011}};
    vec[3] = '{1'b0, 16'd2, 1'b1, 20'd1, 2, {4'b0000, 4'b0000, 4'b0110, 4'b1100, 4'b1001}};
    vec[4] = '{1'b0, 16'd1, 1'b0, 20'd2, 2, {4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b0110}};

    // Reset and idle
    repeat (3) @(posedge clk_1);
    @(negedge clk_1);
    rst_n = 1'b1;
    @(negedge clk_1);
    chk("rst_M", M, 0);
    chk("rst_activo", motor_activo, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_pasos_rest", pasos_rest, 0);
    chk("rst_hecho", hecho, 0);
    chk("rst_abortado", abortado, 0);

    // Table-driven moves
    for (int v = 0; v < 5; v++) begin
      int n, p, tend;
      if (vec[v].rst_first) do_reset();
      n = int'(vec[v].pasos);
      p = vec[v].p_eff;
      tend = (n + 1) * p;
      accept(vec[v].pasos, vec[v].sentido, vec[v].periodo);
      for (int t = 0; t <= tend + 1; t++) begin
        @(negedge clk_1);
        if (t == 0) begin
          chk("mv_activo_on", motor_activo, 1);
          chk("mv_ready_busy", cmd_ready, 0);
        end
        if ((t % p) == 0 && (t / p) <= n) begin
          chk("mv_M_step", M, vec[v].m[t / p]);
          chk("mv_pasos_rest", pasos_rest, n - t / p);
        end
        if (t == tend - 1) begin
          chk("mv_settle_M", M, vec[v].m[n]);
          chk("mv_hecho_early", hecho, 0);
        end
        if (t == tend) begin
          chk("mv_hecho", hecho, 1);
          chk("mv_abortado", abortado, 0);
          chk("mv_M_off", M, 0);
          chk("mv_activo_off", motor_activo, 0);
          chk("mv_ready_idle", cmd_ready, 1);
        end
        if (t == tend + 1) chk("mv_hecho_pulse", hecho, 0);
      end
    end

    // Abort mid-move
    do_reset();
    accept(16'd10, 1'b1, 20'd5);
    for (int t = 0; t <= 14; t++) begin
      @(negedge clk_1);
      if (t == 12) parar = 1'b1;
      if (t == 13) begin
        chk("ab_hecho", hecho, 1);
        chk("ab_abortado", abortado, 1);
        chk("ab_M", M, 0);
        chk("ab_activo", motor_activo, 0);
        chk("ab_pasos_rest", pasos_rest, 8);
        chk("ab_ready_parar", cmd_ready, 0);
        parar = 1'b0;
      end
      if (t == 14) begin
        chk("ab_hecho_pulse", hecho, 0);
        chk("ab_abortado_clr", abortado, 0);
        chk("ab_ready", cmd_ready, 1);
      end
    end

    // Zero-step command
    accept(16'd0, 1'b1, 20'd4);
    @(negedge clk_1);
    chk("z_M0", M, 0);
    chk("z_activo", motor_activo, 0);
    chk("z_hecho_t0", hecho, 0);
    @(negedge clk_1);
    chk("z_hecho_t1", hecho, 1);
    chk("z_abortado", abortado, 0);
    chk("z_M1", M, 0);
    @(negedge clk_1);
    chk("z_hecho_pulse", hecho, 0);

    // parar beats cmd_valid in IDLE
    cmd_pasos = 16'd4; cmd_sentido = 1'b1; cmd_periodo = 20'd3;
    cmd_valid = 1'b1; parar = 1'b1;
    #1 chk("ct_ready_parar", cmd_ready, 0);
    @(negedge clk_1);
    chk("ct_no_accept", motor_activo, 0);
    chk("ct_pasos_rest", pasos_rest, 0);
    cmd_valid = 1'b0; parar = 1'b0;

    // cmd_valid held during a move is ignored
    accept(16'd2, 1'b1, 20'd3);
    cmd_pasos = 16'd7; cmd_valid = 1'b1;
    for (int t = 0; t <= 10; t++) begin
      @(negedge clk_1);
      if (t == 1) begin
        chk("busy_ready", cmd_ready, 0);
        chk("busy_pasos", pasos_rest, 2);
      end
      if (t == 3) chk("busy_pasos_step", pasos_rest, 1);
      if (t == 7) cmd_valid = 1'b0;
      if (t == 9) chk("busy_hecho", hecho, 1);
    end

    // Async reset mid-move
    do_reset();
    accept(16'd3, 1'b1, 20'd4);
    for (int t = 0; t <= 7; t++) @(negedge clk_1);
    chk("ar_pre_M", M, 4'b0110);
    rst_n = 1'b0;
    #1;
    chk("ar_M", M, 0);
    chk("ar_activo", motor_activo, 0);
    chk("ar_pasos_rest", pasos_rest, 0);
    chk("ar_hecho", hecho, 0);
    @(negedge clk_1);
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk_1);
      if (hecho !== 1'b0) chk("ar_no_hecho", hecho, 0);
    end
    chk("ar_idle", motor_activo, 0);
    accept(16'd1, 1'b1, 20'd2);
    @(negedge clk_1);
    chk("ar_index0", M, 4'b1100);
    @(negedge clk_1);
    @(negedge clk_1);
    chk("ar_index1", M, 4'b0110);
    repeat (4) @(negedge clk_1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
